// File: rtl/ex_mul_unit.sv
// ex_mul_unit: iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), shift-add on magnitudes with sign fix-up.
// Define MUL_EARLY_OUT_EN to leave BUSY as soon as the remaining multiplier bits are zero.
module ex_mul_unit #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_flush,
  input  logic        mul_en_e,
  input  logic [4:0]  alu_op_e,
  input  logic        alu_mul_data2_sel_e,
  input  logic [31:0] reg_readdata1_e,
  input  logic [31:0] reg_readdata2_e,
  input  logic [31:0] imm_data_e,
  output logic        mul_stall,
  output logic        mul_valid,
  output logic        mul_busy,
  output logic [31:0] mul_result
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N_ITER = 32 / BITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [1:0]  op;
  logic        neg;
  logic [63:0] a_sh, acc, acc_n, product;
  logic [31:0] b_rem, b_next, op_b, a_mag, b_mag, res_q;
  logic [5:0]  count;
  logic        a_neg, b_neg, start, last;
  logic        unused_op_hi;
  assign unused_op_hi = ^alu_op_e[4:2];
  always_comb begin
    op_b = alu_mul_data2_sel_e ? imm_data_e : reg_readdata2_e;
    a_neg = (alu_op_e[1:0] == 2'b01 || alu_op_e[1:0] == 2'b10) && reg_readdata1_e[31];
    b_neg = alu_op_e[1:0] == 2'b01 && op_b[31];
    a_mag = a_neg ? -reg_readdata1_e : reg_readdata1_e;
    b_mag = b_neg ? -op_b : op_b;
    start = state == IDLE && mul_en_e && !pipe_flush;
    acc_n = acc + a_sh * 64'(b_rem[BPC-1:0]);
    b_next = b_rem >> BPC;
`ifdef MUL_EARLY_OUT_EN
    last = b_next == 32'd0;
`else
    last = count == 6'(N_ITER - 1);
`endif
    product = neg ? -acc : acc;
    state_n = pipe_flush ? IDLE :
              start ? BUSY :
              (state == BUSY && last) ? DONE :
              state == DONE ? IDLE : state;
    mul_stall = start || state == BUSY;
    mul_busy = state != IDLE;
    mul_valid = state == DONE && !pipe_flush;
    mul_result = mul_valid ? (op == 2'b00 ? product[31:0] : product[63:32]) : res_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      neg <= 1'b0;
      a_sh <= '0;
      b_rem <= '0;
      acc <= '0;
      count <= '0;
      res_q <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        op <= alu_op_e[1:0];
        neg <= a_neg ^ b_neg;
        a_sh <= {32'd0, a_mag};
        b_rem <= b_mag;
        acc <= '0;
        count <= '0;
      end else if (state == BUSY) begin
        acc <= acc_n;
        a_sh <= a_sh << BPC;
        b_rem <= b_next;
        count <= count + 6'd1;
      end
      if (mul_valid) res_q <= mul_result;
    end
  end
endmodule
